display_scan_controller: RTL and testbench

- Time-multiplexed driver for the four-digit seven-segment display of the elevator controller.
- Shows current floor, target floor, direction and door/status glyphs.
- Cycles the four anodes with an anti-ghosting blank gap, and double-buffers digit codes through a valid/ready handshake so an update never tears mid-frame.
- Supports per-digit blanking and blinking.

---
 rtl/display_pkg.sv | 35 +++
 rtl/display_scan_if.sv | 24 ++
 rtl/seg7_glyph_decode.sv | 33 +++
 rtl/display_scan_controller.sv | 170 +++++++++++++++++
 tb/tb_display_scan_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package display_pkg;

    // Glyph codes above the decimal digits
    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_UP    = 4'd11;
    localparam logic [3:0] CODE_DOWN  = 4'd12;
    localparam logic [3:0] CODE_DOOR  = 4'd13;
    localparam logic [3:0] CODE_ERR   = 4'd14;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Active-low "everything dark" values
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Four blank codes packed together, the power-up buffer contents
    localparam logic [15:0] CODES_BLANK = {4{CODE_BLANK}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    // Extract the 4-bit code of digit idx from the packed code word
    function automatic logic [3:0] digit_code(input logic [15:0] codes, input logic [1:0] idx);
        return codes[{idx, 2'b00} +: 4];
    endfunction

    // Active-low anode pattern selecting a single digit
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Bundle of the load handshake, masks and display pins of the scan controller.
interface display_scan_if;
    logic        enable;
    logic [15:0] digits_in;
    logic        digits_valid;
    logic        digits_ready;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    // Host side: supplies codes and masks, watches the display pins
    modport master (
        output enable, digits_in, digits_valid, blank_mask, blink_mask,
        input  digits_ready, seg, an, frame_tick
    );

    // Controller side
    modport slave (
        input  enable, digits_in, digits_valid, blank_mask, blink_mask,
        output digits_ready, seg, an, frame_tick
    );
endinterface

// File: rtl/seg7_glyph_decode.sv
// 4-bit glyph code to active-low segments, bit order gfedcba (seg[0] = a).
module seg7_glyph_decode
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    // Glyph lookup table
    always_comb begin
        // NOTE: the default ahead of the case makes every path assign seg_o, so no latch is inferred.
        seg_o = SEG_OFF;
        case (code_i)
            4'd0:      seg_o = 7'b1000000;
            4'd1:      seg_o = 7'b1111001;
            4'd2:      seg_o = 7'b0100100;
            4'd3:      seg_o = 7'b0110000;
            4'd4:      seg_o = 7'b0011001;
            4'd5:      seg_o = 7'b0010010;
            4'd6:      seg_o = 7'b0000010;
            4'd7:      seg_o = 7'b1111000;
            4'd8:      seg_o = 7'b0000000;
            4'd9:      seg_o = 7'b0010000;
            CODE_DASH: seg_o = 7'b0111111;
            CODE_UP:   seg_o = 7'b1000001;
            CODE_DOWN: seg_o = 7'b0100001;
            CODE_DOOR: seg_o = 7'b0001100;
            CODE_ERR:  seg_o = 7'b0000110;
            default:   seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed four-digit seven-segment driver with anti-ghosting blank gap,
// double-buffered digit codes, per-digit blanking and blinking.
// SCAN_DIV must exceed BLANK_CYC.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 125
) (
    input  logic          clk,
    input  logic          rst_n,
    display_scan_if.slave bus
);

    localparam int SLOT_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    scan_state_e        state_q, state_d;
    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [1:0]         digit_q, digit_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [15:0]        active_q, active_d;
    logic [15:0]        pending_q, pending_d;
    logic               ready_q, ready_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               frame_tick_q, frame_tick_d;

    logic               slot_end;
    logic               frame_end;
    logic               lit;
    logic [3:0]         cur_code;
    logic [6:0]         cur_seg;

    // Last DRIVE cycle of a slot, and of digit 3 (end of frame)
    assign slot_end  = bus.enable && (state_q == DRIVE) && (slot_cnt_q == SLOT_LAST);
    assign frame_end = slot_end && (digit_q == 2'd3);

    assign cur_code = digit_code(active_q, digit_q);

    seg7_glyph_decode u_decode (
        .code_i (cur_code),
        .seg_o  (cur_seg)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: flops take <= so every register samples pre-edge values regardless of block order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: blank gap, then drive, then the next digit's gap
    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = BLANK;
                BLANK:   if (slot_cnt_q == BLANK_LAST) state_d = DRIVE;
                DRIVE:   if (slot_end) state_d = BLANK;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: anode and segments for the current slot, registered below
    always_comb begin
        lit          = !bus.blank_mask[digit_q] && !(bus.blink_mask[digit_q] && blink_phase_q);
        an_d         = AN_OFF;
        seg_d        = SEG_OFF;
        frame_tick_d = frame_end;
        if (bus.enable && state_q == DRIVE) begin
            seg_d = cur_seg;
            if (lit) an_d = anode_sel(digit_q);
        end
    end

    // Slot, digit and frame counters plus the blink phase
    always_comb begin
        slot_cnt_d    = slot_cnt_q;
        digit_d       = digit_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!bus.enable) begin
            slot_cnt_d  = '0;
            digit_d     = 2'd0;
            frame_cnt_d = '0;
        end else if (state_q != IDLE) begin
            if (slot_end) begin
                slot_cnt_d = '0;
                digit_d    = digit_q + 2'd1;
            end else begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            end
            if (frame_end) begin
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                end
            end
        end
    end

    // Double buffer: capture into pending when free, commit at frame end (or at once while dark)
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        ready_d   = ready_q;
        if (ready_q) begin
            if (bus.digits_valid) begin
                pending_d = bus.digits_in;
                ready_d   = 1'b0;
            end
        end else if (frame_end || !bus.enable) begin
            active_d = pending_q;
            ready_d  = 1'b1;
        end
    end

    // Counter and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            digit_q       <= 2'd0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            // NOTE: both code buffers are plain flops and reset to blank so nothing stale is shown after reset.
            active_q      <= CODES_BLANK;
            pending_q     <= CODES_BLANK;
            ready_q       <= 1'b1;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            ready_q       <= ready_d;
        end
    end

    // Output registers keep the pins glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an           = an_q;
    assign bus.seg          = seg_q;
    assign bus.frame_tick   = frame_tick_q;
    assign bus.digits_ready = ready_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed self-checking bench for display_scan_controller (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2).
module tb_display_scan_controller;

    localparam int FRAME_LEN = 32;

    // Hand-computed active-low glyphs, gfedcba
    localparam logic [6:0] G_0 = 7'h40, G_1 = 7'h79, G_2 = 7'h24, G_3 = 7'h30;
    localparam logic [6:0] G_4 = 7'h19, G_5 = 7'h12, G_6 = 7'h02, G_7 = 7'h78;
    localparam logic [6:0] G_8 = 7'h00, G_9 = 7'h10, G_DASH = 7'h3F, G_U = 7'h41;
    localparam logic [6:0] G_D = 7'h21, G_P = 7'h0C, G_E = 7'h06, G_BL = 7'h7F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    display_scan_if bus ();

    display_scan_controller #(
        .SCAN_DIV     (8),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] an_cap  [FRAME_LEN];
    logic [6:0] seg_cap [FRAME_LEN];
    logic       ft_cap  [FRAME_LEN];

    // Expected anodes at frame position i (slot = i/8, first 2 cycles of a slot dark)
    function automatic logic [3:0] exp_an(input int i, input logic [3:0] dark);
        int slot;
        int pos;
        slot = i / 8;
        pos  = i % 8;
        if (pos < 2 || dark[slot]) return 4'hF;
        return ~(4'b0001 << slot);
    endfunction

    // Expected segments at frame position i; glyphs packed {d3,d2,d1,d0}
    function automatic logic [6:0] exp_seg(input int i, input logic [27:0] glyphs);
        int slot;
        int pos;
        slot = i / 8;
        pos  = i % 8;
        if (pos < 2) return G_BL;
        return glyphs[slot*7 +: 7];
    endfunction

    // Record one frame of pins, starting the cycle after a frame_tick (or after enable)
    task automatic capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            @(negedge clk);
            an_cap[i]  = bus.an;
            seg_cap[i] = bus.seg;
            ft_cap[i]  = bus.frame_tick;
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.digits_in = 16'h0; bus.digits_valid = 1'b0;
        bus.blank_mask = 4'h0; bus.blink_mask = 4'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++; if (bus.an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
        n_assert++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h expected 7f", bus.seg); end
        n_assert++; if (bus.digits_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.digits_ready); end
        n_assert++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0", bus.frame_tick); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++; if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin n_fail++; $display("FAIL idle_dark: got an=%b seg=%h expected 1111/7f", bus.an, bus.seg); end
    endtask

    task automatic test_scan();
        // enable and load in the same cycle: first frame blank, second shows 4321
        bus.enable = 1'b1; bus.digits_in = 16'h4321; bus.digits_valid = 1'b1;
        @(negedge clk);
        bus.digits_valid = 1'b0;
        n_assert++; if (bus.digits_ready !== 1'b0) begin n_fail++; $display("FAIL scan_ready_low: got %b expected 0", bus.digits_ready); end
        capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (an_cap[i] !== exp_an(i, 4'h0)) begin n_fail++; $display("FAIL scan_f0_an[%0d]: got %b expected %b", i, an_cap[i], exp_an(i, 4'h0)); end
            n_assert++; if (seg_cap[i] !== G_BL) begin n_fail++; $display("FAIL scan_f0_seg[%0d]: got %h expected 7f", i, seg_cap[i]); end
        end
        n_assert++; if (bus.digits_ready !== 1'b1) begin n_fail++; $display("FAIL scan_ready_back: got %b expected 1", bus.digits_ready); end
        capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (an_cap[i] !== exp_an(i, 4'h0)) begin n_fail++; $display("FAIL scan_f1_an[%0d]: got %b expected %b", i, an_cap[i], exp_an(i, 4'h0)); end
            n_assert++; if (seg_cap[i] !== exp_seg(i, {G_4, G_3, G_2, G_1})) begin n_fail++; $display("FAIL scan_f1_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_4, G_3, G_2, G_1})); end
            n_assert++; if (ft_cap[i] !== (i == FRAME_LEN - 1)) begin n_fail++; $display("FAIL scan_tick[%0d]: got %b expected %b", i, ft_cap[i], (i == FRAME_LEN - 1)); end
        end
    endtask

    task automatic test_back_to_back();
        int low_bad;
        low_bad = 0;
        // 5555 accepted at frame start; a second request (9870) waits for the buffer
        fork
            capture_frame();
            begin
                bus.digits_in = 16'h5555; bus.digits_valid = 1'b1;
                @(posedge clk); #1;
                bus.digits_in = 16'h9870;
                for (int i = 0; i < FRAME_LEN - 1; i++) begin
                    @(negedge clk);
                    if (bus.digits_ready !== 1'b0) low_bad++;
                end
                n_assert++; if (low_bad != 0) begin n_fail++; $display("FAIL b2b_ready_held: got %0d cycles high expected 0", low_bad); end
                @(negedge clk);
                n_assert++; if (bus.digits_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise: got %b expected 1", bus.digits_ready); end
            end
        join
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (seg_cap[i] !== exp_seg(i, {G_4, G_3, G_2, G_1})) begin n_fail++; $display("FAIL b2b_f2_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_4, G_3, G_2, G_1})); end
        end
        fork
            capture_frame();
            begin
                @(posedge clk); #1;
                bus.digits_valid = 1'b0;
                @(negedge clk);
                n_assert++; if (bus.digits_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got %b expected 0", bus.digits_ready); end
            end
        join
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (seg_cap[i] !== exp_seg(i, {G_5, G_5, G_5, G_5})) begin n_fail++; $display("FAIL b2b_f3_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_5, G_5, G_5, G_5})); end
        end
        n_assert++; if (bus.digits_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_f3: got %b expected 1", bus.digits_ready); end
        capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (seg_cap[i] !== exp_seg(i, {G_9, G_8, G_7, G_0})) begin n_fail++; $display("FAIL b2b_f4_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_9, G_8, G_7, G_0})); end
        end
    endtask

    task automatic test_blank_mask();
        // digit 2 blanked for one frame while the U/d/P/E codes are queued
        bus.blank_mask = 4'b0100;
        fork
            capture_frame();
            begin
                bus.digits_in = 16'hEDCB; bus.digits_valid = 1'b1;
                @(posedge clk); #1;
                bus.digits_valid = 1'b0;
            end
        join
        bus.blank_mask = 4'b0000;
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (an_cap[i] !== exp_an(i, 4'b0100)) begin n_fail++; $display("FAIL blank_an[%0d]: got %b expected %b", i, an_cap[i], exp_an(i, 4'b0100)); end
            if (i / 8 != 2) begin
                n_assert++; if (seg_cap[i] !== exp_seg(i, {G_9, G_8, G_7, G_0})) begin n_fail++; $display("FAIL blank_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_9, G_8, G_7, G_0})); end
            end
        end
        capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (an_cap[i] !== exp_an(i, 4'h0)) begin n_fail++; $display("FAIL glyph_an[%0d]: got %b expected %b", i, an_cap[i], exp_an(i, 4'h0)); end
            n_assert++; if (seg_cap[i] !== exp_seg(i, {G_E, G_P, G_D, G_U})) begin n_fail++; $display("FAIL glyph_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_E, G_P, G_D, G_U})); end
        end
    endtask

    task automatic test_enable();
        // run into digit 2 drive (frame position 19)
        repeat (20) @(negedge clk);
        n_assert++; if (bus.an !== 4'b1011 || bus.seg !== G_P) begin n_fail++; $display("FAIL en_pre_drop: got an=%b seg=%h expected 1011/%h", bus.an, bus.seg, G_P); end
        bus.enable = 1'b0;
        @(negedge clk);
        n_assert++; if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin n_fail++; $display("FAIL en_drop_dark: got an=%b seg=%h expected 1111/7f", bus.an, bus.seg); end
        bus.digits_in = 16'hFA6F; bus.digits_valid = 1'b1;
        @(posedge clk); #1;
        bus.digits_valid = 1'b0;
        @(negedge clk);
        n_assert++; if (bus.digits_ready !== 1'b0) begin n_fail++; $display("FAIL en_off_capture: got %b expected 0", bus.digits_ready); end
        @(negedge clk);
        n_assert++; if (bus.digits_ready !== 1'b1) begin n_fail++; $display("FAIL en_off_commit: got %b expected 1", bus.digits_ready); end
        n_assert++; if (bus.an !== 4'hF || bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL en_off_idle: got an=%b tick=%b expected 1111/0", bus.an, bus.frame_tick); end
        bus.enable = 1'b1;
        @(negedge clk);
        capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (an_cap[i] !== exp_an(i, 4'h0)) begin n_fail++; $display("FAIL en_restart_an[%0d]: got %b expected %b", i, an_cap[i], exp_an(i, 4'h0)); end
            n_assert++; if (seg_cap[i] !== exp_seg(i, {G_BL, G_DASH, G_6, G_BL})) begin n_fail++; $display("FAIL en_restart_seg[%0d]: got %h expected %h", i, seg_cap[i], exp_seg(i, {G_BL, G_DASH, G_6, G_BL})); end
        end
        n_assert++; if (ft_cap[FRAME_LEN-1] !== 1'b1) begin n_fail++; $display("FAIL en_restart_tick: got %b expected 1", ft_cap[FRAME_LEN-1]); end
    endtask

    task automatic test_async_reset();
        bus.digits_in = 16'h1111; bus.digits_valid = 1'b1;
        @(posedge clk); #1;
        bus.digits_valid = 1'b0;
        repeat (13) @(negedge clk);
        n_assert++; if (bus.an !== 4'b1101 || bus.seg !== G_6 || bus.digits_ready !== 1'b0) begin
            n_fail++; $display("FAIL arst_pre: got an=%b seg=%h ready=%b expected 1101/%h/0", bus.an, bus.seg, bus.digits_ready, G_6);
        end
        #2 rst_n = 1'b0;
        #1;
        n_assert++; if (bus.an !== 4'hF || bus.seg !== 7'h7F) begin n_fail++; $display("FAIL arst_pins: got an=%b seg=%h expected 1111/7f", bus.an, bus.seg); end
        n_assert++; if (bus.digits_ready !== 1'b1 || bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL arst_hs: got ready=%b tick=%b expected 1/0", bus.digits_ready, bus.frame_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        capture_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            n_assert++; if (an_cap[i] !== exp_an(i, 4'h0)) begin n_fail++; $display("FAIL arst_frame_an[%0d]: got %b expected %b", i, an_cap[i], exp_an(i, 4'h0)); end
            n_assert++; if (seg_cap[i] !== G_BL) begin n_fail++; $display("FAIL arst_frame_seg[%0d]: got %h expected 7f", i, seg_cap[i]); end
        end
        n_assert++; if (bus.digits_ready !== 1'b1) begin n_fail++; $display("FAIL arst_pending_lost: got %b expected 1", bus.digits_ready); end
    endtask

    task automatic test_blink();
        logic [5:0] dark_frames;
        logic [3:0] want;
        dark_frames = 6'b001100;
        rst_n = 1'b0; bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.blink_mask = 4'b0001; bus.enable = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 6; f++) begin
            capture_frame();
            want = dark_frames[f] ? 4'hF : 4'hE;
            for (int i = 2; i < 8; i++) begin
                n_assert++; if (an_cap[i] !== want) begin n_fail++; $display("FAIL blink_f%0d_an[%0d]: got %b expected %b", f, i, an_cap[i], want); end
            end
            n_assert++; if (an_cap[10] !== 4'b1101) begin n_fail++; $display("FAIL blink_f%0d_d1: got %b expected 1101", f, an_cap[10]); end
        end
        bus.blink_mask = 4'h0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan();
        test_back_to_back();
        test_blank_mask();
        test_enable();
        test_async_reset();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
